// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types and helpers for the time-multiplexed glitch filter
package filter_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int CNT_W_DEF = 4;

    // Channel-index width; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/filter_step.sv
// rtl/filter_step.sv - combinational debounce step for the one channel being visited
module filter_step
    import filter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             sync_i,
    input  logic             out_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] t_i,
    output logic             out_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             toggle_o
);
    logic [CNT_W:0] inc;

    always_comb begin
        inc      = {1'b0, cnt_i} + {{CNT_W{1'b0}}, 1'b1};
        out_o    = out_i;
        cnt_o    = '0;
        toggle_o = 1'b0;
        if (sync_i != out_i) begin
            // Compare one bit wider so a lowered threshold below the count still toggles.
            if (inc >= {1'b0, t_i}) begin
                out_o    = ~out_i;
                toggle_o = 1'b1;
            end else begin
                cnt_o = inc[CNT_W-1:0];
            end
        end
    end
endmodule

// File: rtl/filter_sched.sv
// rtl/filter_sched.sv - round-robin glitch filter over N_CH inputs; FILTER_SCHED_IRQ_EN adds irq/irq_clr
module filter_sched
    import filter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        thresh,
    input  logic [N_CH-1:0]         sig_in,
    output logic [N_CH-1:0]         sig_out,
    output logic                    edge_valid,
    output logic [ch_w(N_CH)-1:0]   edge_ch,
    output logic                    edge_rise
`ifdef FILTER_SCHED_IRQ_EN
    ,
    input  logic                    irq_clr,
    output logic                    irq
`endif
);
    localparam int IW = ch_w(N_CH);
    localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

    logic [N_CH-1:0]  sync1_q, sync2_q, sig_out_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [IW-1:0]    ptr_q;
    state_e           state_q;
    logic             edge_valid_q, edge_rise_q;
    logic [IW-1:0]    edge_ch_q;

    logic [CNT_W-1:0] t_eff, step_cnt;
    logic             step_out, step_tog;

    assign t_eff = (thresh == '0) ? CNT_W'(1) : thresh;

    filter_step #(.CNT_W(CNT_W)) u_step (
        .sync_i   (sync2_q[ptr_q]),
        .out_i    (sig_out_q[ptr_q]),
        .cnt_i    (cnt_q[ptr_q]),
        .t_i      (t_eff),
        .out_o    (step_out),
        .cnt_o    (step_cnt),
        .toggle_o (step_tog)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sig_out_q    <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            ptr_q        <= '0;
            state_q      <= IDLE;
            edge_valid_q <= 1'b0;
            edge_ch_q    <= '0;
            edge_rise_q  <= 1'b0;
        end else begin
            sync1_q      <= sig_in;
            sync2_q      <= sync1_q;
            edge_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (enable)  state_q <= SCAN;
                SCAN: if (!enable) state_q <= IDLE;
            endcase
            // Visits are gated by enable directly so a falling enable cancels this cycle's visit.
            if (enable) begin
                cnt_q[ptr_q]     <= step_cnt;
                sig_out_q[ptr_q] <= step_out;
                if (step_tog) begin
                    edge_valid_q <= 1'b1;
                    edge_ch_q    <= ptr_q;
                    edge_rise_q  <= step_out;
                end
                ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    assign sig_out    = sig_out_q;
    assign edge_valid = edge_valid_q;
    assign edge_ch    = edge_ch_q;
    assign edge_rise  = edge_rise_q;

`ifdef FILTER_SCHED_IRQ_EN
    logic [N_CH-1:0] pend_q, pend_d;
    logic            irq_q;

    always_comb begin
        pend_d = irq_clr ? '0 : pend_q;
        // Applied after the clear so a coincident event keeps its pending bit.
        if (enable && step_tog) pend_d[ptr_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= |pend_d;
        end
    end

    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_filter_sched.sv
// tb/tb_filter_sched.sv - scoreboard bench for filter_sched (N_CH=4, thresh=3)
module tb_filter_sched;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] thresh = 4'd3;
    logic [3:0] sig_in = 4'b0000;
    logic [3:0] sig_out;
    logic       edge_valid;
    logic [1:0] edge_ch;
    logic       edge_rise;
`ifdef FILTER_SCHED_IRQ_EN
    logic       irq_clr = 1'b0;
    logic       irq;
`endif

    filter_sched #(.N_CH(4), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .thresh     (thresh),
        .sig_in     (sig_in),
        .sig_out    (sig_out),
        .edge_valid (edge_valid),
        .edge_ch    (edge_ch),
        .edge_rise  (edge_rise)
`ifdef FILTER_SCHED_IRQ_EN
        ,
        .irq_clr    (irq_clr),
        .irq        (irq)
`endif
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model, advanced on every rising edge from the same inputs the DUT sees.
    typedef struct { int cyc; int ch; logic rise; } ev_t;
    ev_t        sb[$];
    int         cyc = 0;
    logic [3:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_pend = '0;
    int         m_cnt [4] = '{0, 0, 0, 0};
    int         m_ptr = 0;
    logic       m_irq = 1'b0;

    always @(posedge clock) begin
        int c, t;
        cyc++;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_pend = '0; m_irq = 1'b0;
            m_ptr = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
`ifdef FILTER_SCHED_IRQ_EN
            if (irq_clr) m_pend = '0;
`endif
            if (enable) begin
                c = m_ptr;
                t = (thresh == 0) ? 1 : int'(thresh);
                if (m_s2[c] == m_out[c]) begin
                    m_cnt[c] = 0;
                end else if (m_cnt[c] + 1 >= t) begin
                    m_out[c]  = ~m_out[c];
                    m_cnt[c]  = 0;
                    m_pend[c] = 1'b1;
                    sb.push_back('{cyc, c, m_out[c]});
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
                m_ptr = (m_ptr + 1) % 4;
            end
            m_irq = |m_pend;
            m_s2 = m_s1;
            m_s1 = sig_in;
        end
    end

    int n_ev = 0;
    int ev_log[$];

    always @(negedge clock) begin
        ev_t e;
        check("sig_out", 32'(sig_out), 32'(m_out));
`ifdef FILTER_SCHED_IRQ_EN
        check("irq", 32'(irq), 32'(m_irq));
`endif
        if (edge_valid) begin
            n_ev++;
            ev_log.push_back(int'(edge_ch) * 2 + int'(edge_rise));
            if (sb.size() == 0) begin
                check("ev_spurious", 32'(edge_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ev_ch",   32'(edge_ch),   32'(e.ch));
                check("ev_rise", 32'(edge_rise), 32'(e.rise));
                check("ev_cyc",  32'(cyc),       32'(e.cyc));
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            check("ev_missing", 32'(edge_valid), 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_mcnt(input int ch, input int val, input string tag);
        int k;
        k = 0;
        while (m_cnt[ch] != val && k < 100) begin
            tick(1);
            k++;
        end
        check(tag, 32'(m_cnt[ch] == val), 32'd1);
    endtask

    initial begin
        int base;
        // 1: reset
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_sig_out", 32'(sig_out), 32'd0);
        check("rst_edge_valid", 32'(edge_valid), 32'd0);
        check("rst_ptr", 32'(dut.ptr_q), 32'd0);
        enable = 1'b1;
        tick(2);

        // 2: stable rise then fall on channel 0
        base = n_ev; ev_log.delete();
        sig_in[0] = 1'b1;
        tick(40);
        check("s2_rise_out", 32'(sig_out[0]), 32'd1);
        check("s2_rise_cnt", 32'(n_ev - base), 32'd1);
        check("s2_rise_ev", 32'(ev_log.size() > 0 ? ev_log[0] : -1), 32'd1);
        base = n_ev; ev_log.delete();
        sig_in[0] = 1'b0;
        tick(40);
        check("s2_fall_out", 32'(sig_out[0]), 32'd0);
        check("s2_fall_ev", 32'(ev_log.size() > 0 ? ev_log[0] : -1), 32'd0);

        // 3: short glitch on channel 1
        base = n_ev;
        sig_in[1] = 1'b1;
        tick(6);
        sig_in[1] = 1'b0;
        tick(30);
        check("s3_out", 32'(sig_out[1]), 32'd0);
        check("s3_no_ev", 32'(n_ev - base), 32'd0);
        check("s3_cnt", 32'(dut.cnt_q[1]), 32'd0);

        // 4: simultaneous rises on channels 2 and 3
        ev_log.delete();
        sig_in[3:2] = 2'b11;
        tick(40);
        check("s4_n_ev", 32'(ev_log.size()), 32'd2);
        if (ev_log.size() == 2) begin
            check("s4_first", 32'(ev_log[0]), 32'd5);
            check("s4_second", 32'(ev_log[1]), 32'd7);
        end

        // 5: enable dropped after two mismatching visits, then thresh=0
        sig_in[0] = 1'b1;
        wait_mcnt(0, 2, "s5_reach_cnt2");
        enable = 1'b0;
        base = n_ev;
        tick(20);
        check("s5_hold_out", 32'(sig_out[0]), 32'd0);
        check("s5_hold_cnt", 32'(dut.cnt_q[0]), 32'd2);
        check("s5_hold_no_ev", 32'(n_ev - base), 32'd0);
        enable = 1'b1;
        tick(5);
        check("s5_resume_ev", 32'(n_ev - base), 32'd1);
        check("s5_resume_out", 32'(sig_out[0]), 32'd1);
        thresh = 4'd0;
        base = n_ev;
        sig_in[0] = 1'b0;
        tick(8);
        check("s5_t0_ev", 32'(n_ev - base), 32'd1);
        check("s5_t0_out", 32'(sig_out[0]), 32'd0);
        thresh = 4'd3;

        // 6: reset mid-count
        sig_in[1] = 1'b1;
        wait_mcnt(1, 1, "s6_reach_cnt1");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) check("s6_cnt_clear", 32'(dut.cnt_q[i]), 32'd0);
        check("s6_out_clear", 32'(sig_out), 32'd0);
        check("s6_ptr_clear", 32'(dut.ptr_q), 32'd0);
        tick(60);
        check("s6_relearn", 32'(sig_out), 32'b1110);

`ifdef FILTER_SCHED_IRQ_EN
        check("irq_set", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        check("irq_lone_clr", 32'(irq), 32'd0);
        irq_clr = 1'b1;
        sig_in[0] = 1'b1;
        begin
            int k;
            k = 0;
            while (!edge_valid && k < 60) begin
                tick(1);
                k++;
            end
            check("irq_ev_seen", 32'(edge_valid), 32'd1);
        end
        check("irq_set_wins", 32'(irq), 32'd1);
        tick(1);
        irq_clr = 1'b0;
        check("irq_clr_after", 32'(irq), 32'd0);
`endif

        tick(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
